// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control sequencer.
// Moore outputs from state; BRANCH PCWrite also uses ALU flags.
module mc_control_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction_reg,
  input  logic        alu_zero,
  input  logic        alu_lsb,
  output logic        IorD_reg,
  output logic        IRWrite_reg,
  output logic        MemWrite_reg,
  output logic [3:0]  AluControl_reg,
  output logic        PCWrite_reg,
  output logic        RegWrite_reg,
  output logic [1:0]  AluSrcA_reg,
  output logic [1:0]  AluSrcB_reg,
  output logic [1:0]  ResultSrc_reg,
  output logic [3:0]  AluOp_reg,
  output logic        illegal_reg,
  output logic [3:0]  state_reg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALRADR  = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  state_e     state_q, state_d, nxt;
  logic       illegal_q, illegal_d, bad;
  logic       ir_w, mem_w, pc_w, reg_w, kill;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7;
  logic       unused_ok;

  assign opc = instruction_reg[6:0];
  assign f3  = instruction_reg[14:12];
  assign f7  = instruction_reg[30];
  assign unused_ok = ^{instruction_reg[31],
                       instruction_reg[29:15],
                       instruction_reg[11:7]};

  function automatic logic [3:0] alu_op(
    input logic [2:0] f,
    input logic       alt
  );
    logic [3:0] op;
    unique case (f)
      3'd0:    op = alt ? OP_SUB : OP_ADD;
      3'd1:    op = OP_SLL;
      3'd2:    op = OP_SLT;
      3'd3:    op = OP_SLTU;
      3'd4:    op = OP_XOR;
      3'd5:    op = alt ? OP_SRA : OP_SRL;
      3'd6:    op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    nxt            = state_q;
    bad            = 1'b0;
    ir_w           = 1'b0;
    mem_w          = 1'b0;
    pc_w           = 1'b0;
    reg_w          = 1'b0;
    IorD_reg       = 1'b0;
    AluControl_reg = 4'b0000;
    AluSrcA_reg    = 2'b00;
    AluSrcB_reg    = 2'b00;
    ResultSrc_reg  = 2'b00;
    AluOp_reg      = OP_ADD;
    unique case (state_q)
      S_FETCH: begin
        ir_w          = 1'b1;
        AluSrcB_reg   = 2'b10;
        ResultSrc_reg = 2'b10;
        pc_w          = 1'b1;
        nxt           = S_DECODE;
      end
      S_DECODE: begin
        AluSrcA_reg = 2'b01;
        AluSrcB_reg = 2'b01;
        unique case (opc)
          7'b0000011,
          7'b0100011: nxt = S_MEMADR;
          7'b0110011: nxt = S_EXECR;
          7'b0010011: nxt = S_EXECI;
          7'b1100011: nxt = S_BRANCH;
          7'b1101111: nxt = S_JUMP;
          7'b1100111: nxt = S_JALRADR;
          7'b0110111: nxt = S_LUI;
          7'b0010111: nxt = S_ALUWB;
          7'b0001111: nxt = S_FETCH;
          default:    bad = 1'b1;
        endcase
      end
      S_MEMADR: begin
        AluSrcA_reg    = 2'b10;
        AluSrcB_reg    = 2'b01;
        AluControl_reg = {1'b1, f3};
        if (opc[5]) begin
          nxt = S_MEMWRITE;
          bad = f3 > 3'd2;
        end else begin
          nxt = S_MEMREAD;
          bad = (f3 == 3'd3) || (f3 > 3'd5);
        end
      end
      S_MEMREAD: begin
        IorD_reg       = 1'b1;
        AluControl_reg = {1'b1, f3};
        nxt            = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_reg = 2'b01;
        reg_w         = 1'b1;
        nxt           = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD_reg       = 1'b1;
        mem_w          = 1'b1;
        AluControl_reg = {1'b1, f3};
        nxt            = S_FETCH;
      end
      S_EXECR: begin
        AluSrcA_reg = 2'b10;
        AluOp_reg   = alu_op(f3, f7);
        nxt         = S_ALUWB;
      end
      S_EXECI: begin
        AluSrcA_reg = 2'b10;
        AluSrcB_reg = 2'b01;
        AluOp_reg   = alu_op(f3, f7 && (f3 == 3'd5));
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        nxt   = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA_reg = 2'b10;
        nxt         = S_FETCH;
        // funct3[0] inverts the sense (BNE/BGE/BGEU)
        unique case (f3[2:1])
          2'b00: begin
            AluOp_reg = OP_SUB;
            pc_w      = alu_zero ^ f3[0];
          end
          2'b01: bad = 1'b1;
          2'b10: begin
            AluOp_reg = OP_SLT;
            pc_w      = alu_lsb ^ f3[0];
          end
          default: begin
            AluOp_reg = OP_SLTU;
            pc_w      = alu_lsb ^ f3[0];
          end
        endcase
      end
      S_JALRADR: begin
        AluSrcA_reg = 2'b10;
        AluSrcB_reg = 2'b01;
        nxt         = S_JUMP;
      end
      S_JUMP: begin
        AluSrcA_reg = 2'b01;
        AluSrcB_reg = 2'b10;
        pc_w        = 1'b1;
        nxt         = S_ALUWB;
      end
      S_LUI: begin
        AluSrcA_reg = 2'b11;
        AluSrcB_reg = 2'b01;
        nxt         = S_ALUWB;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase

    if (bad) nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    state_d   = nxt;
    illegal_d = TRAP_ON_ILLEGAL ? (illegal_q | bad) : bad;
    if (stall && (state_q != S_TRAP)) begin
      state_d   = state_q;
      illegal_d = TRAP_ON_ILLEGAL ? illegal_q : 1'b0;
    end
  end

  assign kill         = stall | reset;
  assign IRWrite_reg  = ir_w & ~kill;
  assign MemWrite_reg = mem_w & ~kill;
  assign PCWrite_reg  = pc_w & ~kill;
  assign RegWrite_reg = reg_w & ~kill;
  assign illegal_reg  = illegal_q;
  assign state_reg    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized check of mc_control_fsm against
// a per-instruction path model (trap and skip variants).
module tb_mc_control_fsm;

  typedef struct packed {
    logic       iord;
    logic       irw;
    logic       mw;
    logic [3:0] ac;
    logic       pcw;
    logic       rw;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] r;
    logic [3:0] op;
  } out_t;

  logic        clk = 1'b0;
  logic        reset, stall, alu_zero, alu_lsb;
  logic [31:0] instruction_reg;

  logic       iord, irw, mw, pcw, rw, ill;
  logic [3:0] ac, aop, st;
  logic [1:0] asa, asb, rsrc;
  logic       s_iord, s_irw, s_mw, s_pcw, s_rw, s_ill;
  logic [3:0] s_ac, s_aop, s_st;
  logic [1:0] s_asa, s_asb, s_rsrc;
  out_t       act, s_act;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign act = {iord, irw, mw, ac, pcw, rw,
                asa, asb, rsrc, aop};
  assign s_act = {s_iord, s_irw, s_mw, s_ac, s_pcw,
                  s_rw, s_asa, s_asb, s_rsrc, s_aop};

  mc_control_fsm u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .instruction_reg(instruction_reg),
    .alu_zero(alu_zero), .alu_lsb(alu_lsb),
    .IorD_reg(iord), .IRWrite_reg(irw),
    .MemWrite_reg(mw), .AluControl_reg(ac),
    .PCWrite_reg(pcw), .RegWrite_reg(rw),
    .AluSrcA_reg(asa), .AluSrcB_reg(asb),
    .ResultSrc_reg(rsrc), .AluOp_reg(aop),
    .illegal_reg(ill), .state_reg(st)
  );

  mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) u_skip (
    .clk(clk), .reset(reset), .stall(stall),
    .instruction_reg(instruction_reg),
    .alu_zero(alu_zero), .alu_lsb(alu_lsb),
    .IorD_reg(s_iord), .IRWrite_reg(s_irw),
    .MemWrite_reg(s_mw), .AluControl_reg(s_ac),
    .PCWrite_reg(s_pcw), .RegWrite_reg(s_rw),
    .AluSrcA_reg(s_asa), .AluSrcB_reg(s_asb),
    .ResultSrc_reg(s_rsrc), .AluOp_reg(s_aop),
    .illegal_reg(s_ill), .state_reg(s_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sequence of state codes an instruction walks through.
  task automatic build_path(input logic [31:0] ins,
                            output bit bad);
    logic [2:0] f3;
    f3 = ins[14:12];
    bad = 1'b0;
    exp_q = {};
    exp_q.push_back(0);
    exp_q.push_back(1);
    case (ins[6:0])
      7'b0000011: begin
        exp_q.push_back(2);
        if (f3 == 3 || f3 > 5) bad = 1'b1;
        else begin
          exp_q.push_back(3);
          exp_q.push_back(4);
        end
      end
      7'b0100011: begin
        exp_q.push_back(2);
        if (f3 > 2) bad = 1'b1;
        else exp_q.push_back(5);
      end
      7'b0110011: begin
        exp_q.push_back(6);
        exp_q.push_back(8);
      end
      7'b0010011: begin
        exp_q.push_back(7);
        exp_q.push_back(8);
      end
      7'b1100011: begin
        exp_q.push_back(9);
        if (f3 == 2 || f3 == 3) bad = 1'b1;
      end
      7'b1101111: begin
        exp_q.push_back(11);
        exp_q.push_back(8);
      end
      7'b1100111: begin
        exp_q.push_back(10);
        exp_q.push_back(11);
        exp_q.push_back(8);
      end
      7'b0110111: begin
        exp_q.push_back(12);
        exp_q.push_back(8);
      end
      7'b0010111: exp_q.push_back(8);
      7'b0001111: ;
      default:    bad = 1'b1;
    endcase
  endtask

  function automatic out_t exp_out(input int s,
                                   input logic [31:0] ins,
                                   input logic z,
                                   input logic l,
                                   input logic kill);
    out_t o;
    logic [2:0] f3;
    logic alt;
    int bop[8];
    bop = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = ins[14:12];
    alt = ins[30];
    o = '0;
    case (s)
      0: begin o.irw = 1; o.b = 2; o.r = 2; o.pcw = 1; end
      1: begin o.a = 1; o.b = 1; end
      2: begin o.a = 2; o.b = 1; o.ac = {1'b1, f3}; end
      3: begin o.iord = 1; o.ac = {1'b1, f3}; end
      4: begin o.r = 1; o.rw = 1; end
      5: begin o.iord = 1; o.mw = 1; o.ac = {1'b1, f3}; end
      6: begin
        o.a = 2;
        o.op = 4'(bop[f3] + int'((f3 == 0 || f3 == 5) && alt));
      end
      7: begin
        o.a = 2; o.b = 1;
        o.op = 4'(bop[f3] + int'(f3 == 5 && alt));
      end
      8: o.rw = 1;
      9: begin
        o.a = 2;
        case (f3)
          0: begin o.op = 1; o.pcw = z; end
          1: begin o.op = 1; o.pcw = !z; end
          4: begin o.op = 3; o.pcw = l; end
          5: begin o.op = 3; o.pcw = !l; end
          6: begin o.op = 4; o.pcw = l; end
          7: begin o.op = 4; o.pcw = !l; end
          default: ;
        endcase
      end
      10: begin o.a = 2; o.b = 1; end
      11: begin o.a = 1; o.b = 2; o.pcw = 1; end
      12: begin o.a = 3; o.b = 1; end
      default: ;
    endcase
    if (kill) begin
      o.irw = 0; o.mw = 0; o.pcw = 0; o.rw = 0;
    end
    return o;
  endfunction

  function automatic logic [31:0] rand_ins(input int cls);
    logic [31:0] r;
    int lf3[5];
    int bf3[6];
    lf3 = '{0, 1, 2, 4, 5};
    bf3 = '{0, 1, 4, 5, 6, 7};
    r = $urandom;
    case (cls)
      0: begin
        r[6:0] = 7'b0000011;
        r[14:12] = 3'(lf3[$urandom_range(4)]);
      end
      1: begin
        r[6:0] = 7'b0100011;
        r[14:12] = 3'($urandom_range(2));
      end
      2: r[6:0] = 7'b0110011;
      3: r[6:0] = 7'b0010011;
      4: begin
        r[6:0] = 7'b1100011;
        r[14:12] = 3'(bf3[$urandom_range(5)]);
      end
      5: r[6:0] = 7'b1101111;
      6: r[6:0] = 7'b1100111;
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'b0010111;
      default: r[6:0] = 7'b0001111;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // zf/lf: 0 or 1 forces the flag, 2 randomizes it each cycle
  task automatic run_instr(input logic [31:0] ins,
                           input int zf, input int lf,
                           input int stall_pct,
                           input string tag);
    bit bad;
    int i, guard, stalls;
    logic z, l, s;
    out_t eo;
    build_path(ins, bad);
    instruction_reg = ins;
    i = 0;
    guard = 0;
    stalls = 0;
    while (i < exp_q.size() && guard < 64) begin
      z = (zf == 2) ? 1'($urandom_range(1)) : 1'(zf);
      l = (lf == 2) ? 1'($urandom_range(1)) : 1'(lf);
      s = (stalls < 3) && ($urandom_range(99) < stall_pct);
      alu_zero = z;
      alu_lsb = l;
      stall = s;
      #1;
      checks++;
      if (st !== 4'(exp_q[i]) || s_st !== 4'(exp_q[i])) begin
        errors++;
        $display("FAIL %s state: got %0d/%0d exp %0d",
                 tag, st, s_st, exp_q[i]);
      end
      eo = exp_out(exp_q[i], ins, z, l, s);
      checks++;
      if (act !== eo || s_act !== eo ||
          ill !== 1'b0 || s_ill !== 1'b0) begin
        errors++;
        $display("FAIL %s outs st%0d: got %h/%h ill %b%b exp %h",
                 tag, exp_q[i], act, s_act, ill, s_ill, eo);
      end
      if (s) stalls++;
      else begin
        stalls = 0;
        i++;
      end
      guard++;
      tick();
    end
    stall = 1'b0;
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL %s timeout: got %0d cycles exp <64",
               tag, guard);
    end
  endtask

  task automatic test_reset();
    out_t eo;
    reset = 1'b1;
    stall = 1'b1;
    alu_zero = 1'b1;
    alu_lsb = 1'b1;
    instruction_reg = 32'h0;
    tick();
    tick();
    checks++;
    if (st !== 4'd0 || ill !== 1'b0 || s_ill !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got %0d ill %b exp 0 ill 0",
               st, ill);
    end
    stall = 1'b0;
    #1;
    eo = exp_out(0, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (act !== eo) begin
      errors++;
      $display("FAIL reset strobes: got %h exp %h", act, eo);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_load();
    run_instr(32'h0040A103, 2, 2, 0, "lw");
    run_instr(32'h0040C103, 2, 2, 0, "lbu");
    run_instr(32'h0040D103, 2, 2, 0, "lhu");
  endtask

  task automatic test_store();
    run_instr(32'h00500023, 2, 2, 0, "sb");
  endtask

  task automatic test_branch();
    run_instr(32'h00208463, 1, 2, 0, "beq_t");
    run_instr(32'h00208463, 0, 2, 0, "beq_n");
    run_instr(32'h00209463, 0, 2, 0, "bne_t");
    run_instr(32'h0020C463, 2, 1, 0, "blt_t");
    run_instr(32'h0020C463, 2, 0, 0, "blt_n");
    run_instr(32'h0020F463, 2, 1, 0, "bgeu_n");
    run_instr(32'h0020F463, 2, 0, 0, "bgeu_t");
  endtask

  task automatic test_alu_jump();
    run_instr(32'h402081B3, 2, 2, 0, "sub");
    run_instr(32'h00508093, 2, 2, 0, "addi");
    run_instr(32'h4030D093, 2, 2, 0, "srai");
    run_instr(32'h010000EF, 2, 2, 0, "jal");
    run_instr(32'h000100E7, 2, 2, 0, "jalr");
    run_instr(32'h123450B7, 2, 2, 0, "lui");
    run_instr(32'h00001097, 2, 2, 0, "auipc");
    run_instr(32'h0000000F, 2, 2, 0, "fence");
  endtask

  task automatic test_latency();
    int lat[10];
    int n;
    lat = '{5, 4, 4, 4, 3, 4, 5, 4, 3, 2};
    stall = 1'b0;
    for (int c = 0; c < 10; c++) begin
      instruction_reg = rand_ins(c);
      n = 1;
      tick();
      while (st !== 4'd0 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n != lat[c]) begin
        errors++;
        $display("FAIL latency cls%0d: got %0d exp %0d",
                 c, n, lat[c]);
      end
    end
  endtask

  task automatic test_stall();
    instruction_reg = 32'h00500023;
    stall = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      #1;
      checks++;
      if (st !== 4'd5 || mw !== 1'b0) begin
        errors++;
        $display("FAIL stall hold: got st %0d mw %b exp 5 0",
                 st, mw);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (st !== 4'd5 || mw !== 1'b1 || iord !== 1'b1 ||
        ac !== 4'b1000) begin
      errors++;
      $display("FAIL stall release: got %0d %b %b %b exp 5 1 1 1000",
               st, mw, iord, ac);
    end
    tick();
    checks++;
    if (st !== 4'd0) begin
      errors++;
      $display("FAIL stall done: got %0d exp 0", st);
    end
  endtask

  task automatic test_reset_mid();
    instruction_reg = 32'h0040A103;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (st !== 4'd3 || {irw, mw, pcw, rw} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid hold: got st %0d %b exp 3 0000",
               st, {irw, mw, pcw, rw});
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (st !== 4'd0 || rw !== 1'b0 || irw !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid fetch: got %0d rw %b irw %b exp 0 0 1",
               st, rw, irw);
    end
  endtask

  task automatic run_illegal(input logic [31:0] ins,
                             input string tag);
    bit bad;
    out_t eo;
    do_reset();
    build_path(ins, bad);
    instruction_reg = ins;
    stall = 1'b0;
    alu_zero = 1'b1;
    alu_lsb = 1'b1;
    foreach (exp_q[i]) begin
      #1;
      eo = exp_out(exp_q[i], ins, 1'b1, 1'b1, 1'b0);
      checks++;
      if (st !== 4'(exp_q[i]) || s_st !== 4'(exp_q[i]) ||
          act !== eo) begin
        errors++;
        $display("FAIL %s path: got %0d/%0d %h exp %0d %h",
                 tag, st, s_st, act, exp_q[i], eo);
      end
      tick();
    end
    checks++;
    if (!bad || st !== 4'd13 || ill !== 1'b1 ||
        s_st !== 4'd0 || s_ill !== 1'b1) begin
      errors++;
      $display("FAIL %s enter: got %0d %b / %0d %b exp 13 1 / 0 1",
               tag, st, ill, s_st, s_ill);
    end
    tick();
    checks++;
    if (s_ill !== 1'b0 || s_st !== 4'd1) begin
      errors++;
      $display("FAIL %s pulse: got ill %b st %0d exp 0 1",
               tag, s_ill, s_st);
    end
    for (int k = 0; k < 10; k++) begin
      stall = 1'($urandom_range(1));
      alu_zero = 1'($urandom_range(1));
      alu_lsb = 1'($urandom_range(1));
      #1;
      checks++;
      if (st !== 4'd13 || ill !== 1'b1 || act !== out_t'(0)) begin
        errors++;
        $display("FAIL %s trap: got %0d %b %h exp 13 1 0",
                 tag, st, ill, act);
      end
      tick();
    end
    do_reset();
    #1;
    checks++;
    if (st !== 4'd0 || ill !== 1'b0 || s_ill !== 1'b0) begin
      errors++;
      $display("FAIL %s reset: got %0d %b exp 0 0",
               tag, st, ill);
    end
  endtask

  task automatic test_illegal();
    run_illegal(32'hFFFFFFFF, "ill_ones");
    run_illegal(32'h00000073, "ill_sys");
    run_illegal(32'h00003003, "ill_ld3");
    run_illegal(32'h00003023, "ill_st3");
    run_illegal(32'h00002063, "ill_br2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++)
      run_instr(rand_ins($urandom_range(9)), 2, 2, 25, "rand");
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    alu_zero = 1'b0;
    alu_lsb = 1'b0;
    instruction_reg = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_alu_jump();
    test_latency();
    test_stall();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
